// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: FSM encoding, default sizes and operand-slice helper for adder_arbiter
package adder_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ = 4;
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction
endpackage

// File: rtl/adder_arbiter_rr_picker.sv
// rr_picker: first set request bit scanning upward from ptr with wrap
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);
  logic [IW-1:0] cand;
  always_comb begin
    valid = |req;
    idx = '0;
    cand = '0;
    // scan farthest offset first so the nearest match overwrites
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (req[cand]) idx = cand;
    end
  end
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sequencer sharing one registered adder among NREQ requesters
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ*WIDTH-1:0] Req_A,
  input  logic [NREQ*WIDTH-1:0] Req_B,
  output logic [NREQ-1:0]       Gnt,
  output logic [NREQ-1:0]       Done,
  output logic [WIDTH-1:0]      Res_Sum,
  output logic                  Res_Ovf,
  output logic                  Busy,
  output logic [WIDTH-1:0]      Add_A,
  output logic [WIDTH-1:0]      Add_B,
  output logic                  Add_En,
  input  logic [WIDTH-1:0]      Add_Sum,
  input  logic                  Add_Ovf
);
  localparam int IW = $clog2(NREQ);
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, pick_idx;
  logic pick_valid;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic ovf_q, ovf_d;
  rr_picker #(.NREQ(NREQ)) u_pick (
    .req(Req),
    .ptr(ptr_q),
    .valid(pick_valid),
    .idx(pick_idx)
  );
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (pick_valid) begin
        idx_d = pick_idx;
        a_d = Req_A[slice_lo(int'(pick_idx), WIDTH) +: WIDTH];
        b_d = Req_B[slice_lo(int'(pick_idx), WIDTH) +: WIDTH];
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        sum_d = Add_Sum;
        ovf_d = Add_Ovf;
        state_d = RESP;
      end
      RESP: begin
        ptr_d = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      idx_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end
  assign Busy = state_q != IDLE;
  assign Gnt = Busy ? NREQ'(1) << idx_q : '0;
  assign Done = (state_q == RESP) ? NREQ'(1) << idx_q : '0;
  assign Add_En = state_q == ISSUE;
  assign Add_A = a_q;
  assign Add_B = b_q;
  assign Res_Sum = sum_q;
  assign Res_Ovf = ovf_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed vectors against adder_arbiter with a registered adder stub
module tb_adder_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [15:0] req_a = '0, req_b = '0;
  logic [3:0] gnt, done, res_sum, add_a, add_b;
  logic res_ovf, busy, add_en;
  logic [3:0] add_sum = '0;
  logic add_ovf = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  adder_arbiter #(.NREQ(4), .WIDTH(4)) dut (
    .Clk(clk), .Rst_n(rst_n), .Req(req), .Req_A(req_a), .Req_B(req_b),
    .Gnt(gnt), .Done(done), .Res_Sum(res_sum), .Res_Ovf(res_ovf), .Busy(busy),
    .Add_A(add_a), .Add_B(add_b), .Add_En(add_en), .Add_Sum(add_sum), .Add_Ovf(add_ovf)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk) begin
    if (add_en) begin
      add_sum <= add_a + add_b;
      add_ovf <= (add_a[3] == add_b[3]) && ((add_a + add_b) >> 3 & 4'd1) != {3'd0, add_a[3]};
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ops(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[i*4 +: 4] = a;
    req_b[i*4 +: 4] = b;
  endtask
  task automatic xact(input string tag, input logic [3:0] g, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] sum, input logic ovf, input logic [3:0] req_after);
    tick();
    chk({tag, ".en"}, add_en, 1);
    chk({tag, ".gnt_issue"}, gnt, g);
    chk({tag, ".add_a"}, add_a, a);
    chk({tag, ".add_b"}, add_b, b);
    tick();
    chk({tag, ".gnt_wait"}, gnt, g);
    chk({tag, ".en_wait"}, add_en, 0);
    chk({tag, ".done_wait"}, done, 0);
    tick();
    chk({tag, ".done"}, done, g);
    chk({tag, ".gnt_resp"}, gnt, g);
    chk({tag, ".sum"}, res_sum, sum);
    chk({tag, ".ovf"}, res_ovf, ovf);
    req = req_after;
    tick();
    chk({tag, ".done_off"}, done, 0);
    chk({tag, ".busy_off"}, busy, 0);
  endtask
  initial begin
    #2;
    chk("rst.gnt", gnt, 0);
    chk("rst.done", done, 0);
    chk("rst.busy", busy, 0);
    chk("rst.en", add_en, 0);
    chk("rst.add_a", add_a, 0);
    chk("rst.add_b", add_b, 0);
    chk("rst.sum", res_sum, 0);
    chk("rst.ovf", res_ovf, 0);
    tick();
    rst_n = 1'b1;
    tick();
    ops(0, 4'h3, 4'h4);
    req = 4'b0001;
    xact("single", 4'b0001, 4'h3, 4'h4, 4'h7, 1'b0, 4'b0000);
    ops(1, 4'h7, 4'h1);
    req = 4'b0010;
    xact("ovf", 4'b0010, 4'h7, 4'h1, 4'h8, 1'b1, 4'b0000);
    ops(1, 4'hF, 4'h1);
    req = 4'b0010;
    xact("wrap", 4'b0010, 4'hF, 4'h1, 4'h0, 1'b0, 4'b0000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    ops(0, 4'h0, 4'h1);
    ops(1, 4'h2, 4'h3);
    ops(2, 4'h4, 4'h5);
    ops(3, 4'h6, 4'h7);
    req = 4'b1111;
    xact("full0", 4'b0001, 4'h0, 4'h1, 4'h1, 1'b0, 4'b1110);
    xact("full1", 4'b0010, 4'h2, 4'h3, 4'h5, 1'b0, 4'b1100);
    xact("full2", 4'b0100, 4'h4, 4'h5, 4'h9, 1'b1, 4'b1000);
    xact("full3", 4'b1000, 4'h6, 4'h7, 4'hD, 1'b1, 4'b0000);
    ops(2, 4'h1, 4'h1);
    req = 4'b0100;
    xact("ptr3", 4'b0100, 4'h1, 4'h1, 4'h2, 1'b0, 4'b0000);
    ops(3, 4'h2, 4'h2);
    ops(0, 4'h5, 4'h1);
    req = 4'b1001;
    xact("fair3", 4'b1000, 4'h2, 4'h2, 4'h4, 1'b0, 4'b0001);
    xact("fair0", 4'b0001, 4'h5, 4'h1, 4'h6, 1'b0, 4'b0000);
    ops(2, 4'h3, 4'h3);
    ops(0, 4'h1, 4'h1);
    req = 4'b0101;
    xact("fair2", 4'b0100, 4'h3, 4'h3, 4'h6, 1'b0, 4'b0001);
    xact("fair0b", 4'b0001, 4'h1, 4'h1, 4'h2, 1'b0, 4'b0000);
    ops(0, 4'h2, 4'h2);
    req = 4'b0001;
    tick();
    tick();
    req = 4'b0000;
    tick();
    chk("drop.done", done, 4'b0001);
    chk("drop.sum", res_sum, 4'h4);
    tick();
    ops(1, 4'h1, 4'h2);
    req = 4'b0010;
    tick();
    ops(1, 4'h9, 4'h9);
    tick();
    req = 4'b0000;
    tick();
    chk("late.done", done, 4'b0010);
    chk("late.sum", res_sum, 4'h3);
    chk("late.ovf", res_ovf, 0);
    tick();
    ops(2, 4'h3, 4'h3);
    req = 4'b0100;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.gnt", gnt, 0);
    chk("arst.busy", busy, 0);
    chk("arst.en", add_en, 0);
    chk("arst.sum", res_sum, 0);
    tick();
    chk("arst.done", done, 0);
    req = 4'b0000;
    rst_n = 1'b1;
    tick();
    chk("arst.done2", done, 0);
    ops(0, 4'h1, 4'h2);
    req = 4'b0101;
    xact("arst.first0", 4'b0001, 4'h1, 4'h2, 4'h3, 1'b0, 4'b0100);
    xact("arst.then2", 4'b0100, 4'h3, 4'h3, 4'h6, 1'b0, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle.en", add_en, 0);
      chk("idle.busy", busy, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
